// File: rtl/link_arbiter_if.sv
// Bundle of source-side request/packet signals and the downstream put/free link.
// The slave modport is the arbiter's view. The master modport is the view of the
// sources and the downstream buffer.
interface link_arbiter_if #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
);
  logic [N-1:0]    req;
  logic [N*32-1:0] pkt_in;
  logic [N-1:0]    ack;
  logic            free_out;
  logic            put_out;
  logic [7:0]      payload_out;
  logic            busy;
  logic [PW-1:0]   cur_src;

  modport master (
    output req, pkt_in, free_out,
    input  ack, put_out, payload_out, busy, cur_src
  );

  modport slave (
    input  req, pkt_in, free_out,
    output ack, put_out, payload_out, busy, cur_src
  );
endinterface

// File: rtl/link_arbiter.sv
// Round-robin scheduler for one byte-serial put/free link shared by N sources.
// It grants one source and latches that source's 32-bit packet. It then sends the
// packet as four bytes, MSB byte first.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no packet held; grants the next requester from rr_ptr
// WAIT_FREE | packet latched; waits for free_out, then sends byte 0
// SEND      | sends bytes 1..3; free_out is ignored so the burst never gaps
module link_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_b,
  link_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WAIT_FREE, SEND} state_t;

  state_t        state;
  logic [1:0]    byte_cnt;
  logic [31:0]   pkt_q;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] cur_src_q;

  logic          grant_vld;
  logic [PW-1:0] grant_idx;
  logic [31:0]   grant_pkt;
  logic [PW:0]   scan_sum;
  logic [PW-1:0] scan_idx;

  logic [N-1:0]  ack_c;
  logic          put_c;
  logic [7:0]    payload_c;

  // Round-robin search that starts at rr_ptr. Indices wrap modulo N, so indices >= N never appear.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    grant_pkt = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < N; k++) begin
      scan_sum = {1'b0, rr_ptr} + (PW+1)'(k);
      if (scan_sum >= (PW+1)'(N))
        scan_sum = scan_sum - (PW+1)'(N);
      scan_idx = scan_sum[PW-1:0];
      if (!grant_vld && bus.req[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
        grant_pkt = bus.pkt_in[{scan_idx, 5'd0} +: 32];
      end
    end
  end

  // The ack pulse appears only in IDLE and is held low while reset is asserted. It does not depend on free_out.
  always_comb begin
    ack_c = '0;
    if (rst_b && state == IDLE && grant_vld)
      ack_c[grant_idx] = 1'b1;
  end

  // Link outputs are decoded from the registered state. Byte 0 goes out in the same cycle that free_out is seen high.
  always_comb begin
    put_c     = 1'b0;
    payload_c = 8'h00;
    case (state)
      WAIT_FREE: begin
        if (bus.free_out) begin
          put_c     = 1'b1;
          payload_c = pkt_q[31:24];
        end
      end
      SEND: begin
        put_c = 1'b1;
        case (byte_cnt)
          2'd1:    payload_c = pkt_q[23:16];
          2'd2:    payload_c = pkt_q[15:8];
          default: payload_c = pkt_q[7:0];
        endcase
      end
      default: begin
        put_c     = 1'b0;
        payload_c = 8'h00;
      end
    endcase
  end

  // Sequencer: grant and latch, wait for free, then four back-to-back bytes. Reset drops any packet that is partly sent.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= IDLE;
      byte_cnt  <= 2'd0;
      pkt_q     <= 32'h0;
      rr_ptr    <= '0;
      cur_src_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            pkt_q     <= grant_pkt;
            cur_src_q <= grant_idx;
            if (grant_idx == PW'(N-1))
              rr_ptr <= '0;
            else
              rr_ptr <= grant_idx + PW'(1);
            state <= WAIT_FREE;
          end
        end
        WAIT_FREE: begin
          if (bus.free_out) begin
            byte_cnt <= 2'd1;
            state    <= SEND;
          end
        end
        SEND: begin
          if (byte_cnt == 2'd3) begin
            byte_cnt <= 2'd0;
            state    <= IDLE;
          end else begin
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        default: begin
          byte_cnt <= 2'd0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack         = ack_c;
  assign bus.put_out     = put_c;
  assign bus.payload_out = payload_c;
  assign bus.busy        = (state != IDLE);
  assign bus.cur_src     = cur_src_q;

endmodule
